// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage with PC, next-PC select, IF/ID register and sticky halt
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  jb_flag,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_addr,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        halted,
    output logic [31:0] instr_count
);
    typedef enum logic {FETCH, HALTED} state_t;
    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect;
    assign pc_plus4  = pc + 32'd4;
    assign redirect  = (jb_flag == 2'b01) || (jb_flag == 2'b10);
    assign imem_addr = pc;
    assign halted    = (state == HALTED);
    // Halt dominates stall; stall freezes everything; redirect squashes the wrong-path fetch before any halt check
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state          <= FETCH;
            pc             <= RESET_PC;
            if_id_instr    <= 32'd0;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
            instr_count    <= 32'd0;
        end else if (state == HALTED) begin
            if_id_instr    <= 32'd0;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
        end else if (!stall) begin
            if (redirect || imem_data == HALT_WORD) begin
                if_id_instr    <= 32'd0;
                if_id_pc_plus4 <= 32'd0;
                if_id_valid    <= 1'b0;
                if (redirect)
                    pc <= (jb_flag == 2'b01) ? branch_target : jump_addr;
                else
                    state <= HALTED;
            end else begin
                pc             <= pc_plus4;
                if_id_instr    <= imem_data;
                if_id_pc_plus4 <= pc_plus4;
                if_id_valid    <= 1'b1;
                instr_count    <= instr_count + 32'd1;
            end
        end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios for fetch_stage against a small instruction memory
module tb_fetch_stage;
    logic        clk = 0;
    logic        reset = 1;
    logic        stall = 0;
    logic [1:0]  jb_flag = 2'b00;
    logic [31:0] branch_target = 0;
    logic [31:0] jump_addr = 0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] instr_count;
    logic [31:0] mem [0:255];
    int          pass_cnt = 0;
    int          total_cnt = 0;

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .jb_flag(jb_flag),
        .branch_target(branch_target), .jump_addr(jump_addr),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid(if_id_valid), .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;
    assign imem_data = mem[imem_addr[9:2]];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        stall = 0; jb_flag = 2'b00;
        reset = 1;
        #2;
        @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        #1;
        total_cnt++; if (imem_addr !== 32'h0) $display("FAIL reset_addr got %h want %h", imem_addr, 32'h0); else pass_cnt++;
        total_cnt++; if (if_id_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", if_id_valid); else pass_cnt++;
        total_cnt++; if (instr_count !== 32'h0) $display("FAIL reset_count got %0d want 0", instr_count); else pass_cnt++;
        total_cnt++; if (halted !== 1'b0) $display("FAIL reset_halted got %b want 0", halted); else pass_cnt++;
        total_cnt++; if (if_id_instr !== 32'h0) $display("FAIL reset_instr got %h want 0", if_id_instr); else pass_cnt++;
        do_reset();
        for (int i = 0; i < 16; i++) step();
        total_cnt++; if (imem_addr !== 32'h40) $display("FAIL pre_async_addr got %h want 40", imem_addr); else pass_cnt++;
        total_cnt++; if (instr_count !== 32'd16) $display("FAIL pre_async_count got %0d want 16", instr_count); else pass_cnt++;
        #3 reset = 1;
        #1;
        total_cnt++; if (imem_addr !== 32'h0) $display("FAIL async_addr got %h want 0", imem_addr); else pass_cnt++;
        total_cnt++; if (if_id_valid !== 1'b0) $display("FAIL async_valid got %b want 0", if_id_valid); else pass_cnt++;
        total_cnt++; if (instr_count !== 32'h0) $display("FAIL async_count got %0d want 0", instr_count); else pass_cnt++;
        total_cnt++; if (if_id_pc_plus4 !== 32'h0) $display("FAIL async_pc4 got %h want 0", if_id_pc_plus4); else pass_cnt++;
    endtask

    task automatic test_sequential();
        do_reset();
        step();
        total_cnt++; if (if_id_instr !== 32'h20080005) $display("FAIL seq1_instr got %h want 20080005", if_id_instr); else pass_cnt++;
        total_cnt++; if (if_id_pc_plus4 !== 32'h4) $display("FAIL seq1_pc4 got %h want 4", if_id_pc_plus4); else pass_cnt++;
        total_cnt++; if (if_id_valid !== 1'b1) $display("FAIL seq1_valid got %b want 1", if_id_valid); else pass_cnt++;
        step();
        total_cnt++; if (if_id_instr !== 32'h20090003) $display("FAIL seq2_instr got %h want 20090003", if_id_instr); else pass_cnt++;
        total_cnt++; if (if_id_pc_plus4 !== 32'h8) $display("FAIL seq2_pc4 got %h want 8", if_id_pc_plus4); else pass_cnt++;
        step();
        total_cnt++; if (imem_addr !== 32'hC) $display("FAIL seq3_addr got %h want c", imem_addr); else pass_cnt++;
        total_cnt++; if (instr_count !== 32'd3) $display("FAIL seq3_count got %0d want 3", instr_count); else pass_cnt++;
    endtask

    task automatic test_stall();
        do_reset();
        step(); step();
        stall = 1;
        step(); step();
        total_cnt++; if (imem_addr !== 32'h8) $display("FAIL stall_addr got %h want 8", imem_addr); else pass_cnt++;
        total_cnt++; if (if_id_instr !== 32'h20090003) $display("FAIL stall_instr got %h want 20090003", if_id_instr); else pass_cnt++;
        total_cnt++; if (if_id_pc_plus4 !== 32'h8) $display("FAIL stall_pc4 got %h want 8", if_id_pc_plus4); else pass_cnt++;
        total_cnt++; if (instr_count !== 32'd2) $display("FAIL stall_count got %0d want 2", instr_count); else pass_cnt++;
        stall = 0;
        step();
        total_cnt++; if (if_id_instr !== 32'h20000002) $display("FAIL unstall_instr got %h want 20000002", if_id_instr); else pass_cnt++;
        total_cnt++; if (imem_addr !== 32'hC) $display("FAIL unstall_addr got %h want c", imem_addr); else pass_cnt++;
    endtask

    task automatic test_redirect();
        step();
        jb_flag = 2'b01; branch_target = 32'h100;
        step();
        total_cnt++; if (imem_addr !== 32'h100) $display("FAIL br_addr got %h want 100", imem_addr); else pass_cnt++;
        total_cnt++; if (if_id_valid !== 1'b0) $display("FAIL br_bubble got %b want 0", if_id_valid); else pass_cnt++;
        total_cnt++; if (instr_count !== 32'd4) $display("FAIL br_count got %0d want 4", instr_count); else pass_cnt++;
        jb_flag = 2'b00;
        step();
        total_cnt++; if (if_id_instr !== 32'h20000040) $display("FAIL br_instr got %h want 20000040", if_id_instr); else pass_cnt++;
        total_cnt++; if (if_id_pc_plus4 !== 32'h104) $display("FAIL br_pc4 got %h want 104", if_id_pc_plus4); else pass_cnt++;
        jb_flag = 2'b10; jump_addr = 32'h200;
        step();
        total_cnt++; if (imem_addr !== 32'h200) $display("FAIL jmp_addr got %h want 200", imem_addr); else pass_cnt++;
        total_cnt++; if (if_id_valid !== 1'b0) $display("FAIL jmp_bubble got %b want 0", if_id_valid); else pass_cnt++;
        jb_flag = 2'b00;
        step();
        total_cnt++; if (if_id_instr !== 32'h20000080) $display("FAIL jmp_instr got %h want 20000080", if_id_instr); else pass_cnt++;
        total_cnt++; if (if_id_pc_plus4 !== 32'h204) $display("FAIL jmp_pc4 got %h want 204", if_id_pc_plus4); else pass_cnt++;
        jb_flag = 2'b11; branch_target = 32'h300; jump_addr = 32'h300;
        step();
        total_cnt++; if (imem_addr !== 32'h208) $display("FAIL jb11_addr got %h want 208", imem_addr); else pass_cnt++;
        total_cnt++; if (if_id_instr !== 32'h20000081) $display("FAIL jb11_instr got %h want 20000081", if_id_instr); else pass_cnt++;
        total_cnt++; if (instr_count !== 32'd7) $display("FAIL jb11_count got %0d want 7", instr_count); else pass_cnt++;
        jb_flag = 2'b00;
    endtask

    task automatic test_stall_redirect();
        jb_flag = 2'b10; jump_addr = 32'h40; stall = 1;
        step();
        total_cnt++; if (imem_addr !== 32'h208) $display("FAIL stj_addr got %h want 208", imem_addr); else pass_cnt++;
        total_cnt++; if (if_id_valid !== 1'b1) $display("FAIL stj_valid got %b want 1", if_id_valid); else pass_cnt++;
        total_cnt++; if (if_id_instr !== 32'h20000081) $display("FAIL stj_instr got %h want 20000081", if_id_instr); else pass_cnt++;
        stall = 0;
        step();
        total_cnt++; if (imem_addr !== 32'h40) $display("FAIL stj2_addr got %h want 40", imem_addr); else pass_cnt++;
        total_cnt++; if (if_id_valid !== 1'b0) $display("FAIL stj2_valid got %b want 0", if_id_valid); else pass_cnt++;
        jb_flag = 2'b00;
    endtask

    task automatic test_wrap();
        jb_flag = 2'b10; jump_addr = 32'hFFFF_FFFC;
        step();
        jb_flag = 2'b00;
        step();
        total_cnt++; if (imem_addr !== 32'h0) $display("FAIL wrap_addr got %h want 0", imem_addr); else pass_cnt++;
        total_cnt++; if (if_id_pc_plus4 !== 32'h0) $display("FAIL wrap_pc4 got %h want 0", if_id_pc_plus4); else pass_cnt++;
        total_cnt++; if (if_id_instr !== 32'h200000FF) $display("FAIL wrap_instr got %h want 200000ff", if_id_instr); else pass_cnt++;
        total_cnt++; if (if_id_valid !== 1'b1) $display("FAIL wrap_valid got %b want 1", if_id_valid); else pass_cnt++;
    endtask

    task automatic test_halt();
        mem[8] = 32'hFFFF_FFFF;
        do_reset();
        for (int i = 0; i < 8; i++) step();
        total_cnt++; if (imem_addr !== 32'h20) $display("FAIL prehalt_addr got %h want 20", imem_addr); else pass_cnt++;
        step();
        total_cnt++; if (halted !== 1'b1) $display("FAIL halt_flag got %b want 1", halted); else pass_cnt++;
        total_cnt++; if (imem_addr !== 32'h20) $display("FAIL halt_addr got %h want 20", imem_addr); else pass_cnt++;
        total_cnt++; if (if_id_valid !== 1'b0) $display("FAIL halt_valid got %b want 0", if_id_valid); else pass_cnt++;
        total_cnt++; if (instr_count !== 32'd8) $display("FAIL halt_count got %0d want 8", instr_count); else pass_cnt++;
        jb_flag = 2'b01; branch_target = 32'h100;
        step(); step();
        total_cnt++; if (imem_addr !== 32'h20) $display("FAIL halt_br_addr got %h want 20", imem_addr); else pass_cnt++;
        total_cnt++; if (halted !== 1'b1) $display("FAIL halt_sticky got %b want 1", halted); else pass_cnt++;
        total_cnt++; if (if_id_valid !== 1'b0) $display("FAIL halt_br_valid got %b want 0", if_id_valid); else pass_cnt++;
        do_reset();
        for (int i = 0; i < 8; i++) step();
        jb_flag = 2'b01; branch_target = 32'h100;
        step();
        total_cnt++; if (halted !== 1'b0) $display("FAIL redir_halt got %b want 0", halted); else pass_cnt++;
        total_cnt++; if (imem_addr !== 32'h100) $display("FAIL redir_halt_addr got %h want 100", imem_addr); else pass_cnt++;
        jb_flag = 2'b00;
        step();
        total_cnt++; if (if_id_instr !== 32'h20000040) $display("FAIL redir_halt_instr got %h want 20000040", if_id_instr); else pass_cnt++;
        total_cnt++; if (instr_count !== 32'd9) $display("FAIL redir_halt_count got %0d want 9", instr_count); else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h2000_0000 + i;
        mem[0] = 32'h20080005;
        mem[1] = 32'h20090003;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_stall_redirect();
        test_wrap();
        test_halt();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline. Sits directly upstream of the decode/control stage.
- Owns the PC and drives the instruction-memory address.
- Selects the next PC from the redirect flag produced in ID (sequential / branch / jump).
- Hands the fetched instruction and PC+4 to decode.
- Handles hazard stalls, wrong-path flushes and a sticky halt.

Parameters:
RESET_PC, 32'h0000_0000, byte address loaded into PC on reset.
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; clears all state
stall  input  1  from hazard unit; freeze PC and IF/ID this cycle
jb_flag  input  2  from ID: 00 sequential, 01 taken branch, 10 jump/jr, 11 treated as 00
branch_target  input  32  ID-computed branch target (byte address)
jump_addr  input  32  ID-computed jump target ({PC+4[31:28],imm26,00} or rs)
imem_addr  output  32  = PC, byte address, combinational from PC register
imem_data  input  32  instruction at imem_addr, combinational (same-cycle) read
if_id_instr  output  32  registered instruction to ID
if_id_pc_plus4  output  32  registered PC+4 of that instruction (for link/branch math)
if_id_valid  output  1  1 = real instruction, 0 = bubble
halted  output  1  sticky; fetch stopped
instr_count  output  32  number of valid instructions delivered into IF/ID

Behaviour:
- Reset (async, any time, including mid-stall or mid-redirect):
  - PC=RESET_PC, if_id_instr=0 (nop), if_id_pc_plus4=0, if_id_valid=0, halted=0, instr_count=0.
  - First fetch occurs on the first rising edge after reset deasserts.
- pc_plus4 = PC + 32'd4, modulo 2^32. PC 32'hFFFF_FFFC wraps to 0.
- redirect = (jb_flag==01) | (jb_flag==10).
- Per-edge priority, highest first:
  1. halted=1: PC held; IF/ID loads bubble (instr=0, pc_plus4=0, valid=0); stall and jb_flag ignored; instr_count held.
  2. stall=1: PC, IF/ID and instr_count all hold. Any redirect this cycle is ignored; ID re-presents it after the stall.
  3. redirect=1: PC <= branch_target (01) or jump_addr (10). IF/ID loads bubble, because the instruction currently fetched is wrong-path (no delay slot). No halt detection this cycle.
  4. imem_data==HALT_WORD: halted <= 1, PC held, IF/ID loads bubble. The halt word is never passed to ID.
  5. Otherwise: PC <= pc_plus4; if_id_instr <= imem_data; if_id_pc_plus4 <= pc_plus4; if_id_valid <= 1; instr_count <= instr_count+1 (wraps 2^32-1 -> 0).
- Latency:
  - Instruction fetched in cycle N appears on if_id_* in cycle N+1.
  - Redirect asserted in cycle N: target address on imem_addr in N+1; target instruction on if_id_* in N+2; exactly one bubble is inserted.
- State machine, 2 states:
  - FETCH -> HALTED on condition 4.
  - HALTED is exited only by reset.
- Branch/jump targets are not alignment-checked; low two bits pass through to imem_addr.
- Outputs are registered except imem_addr, which equals the PC register.

Test Plan:
1. Reset with RESET_PC=0 -> imem_addr=0, if_id_valid=0, instr_count=0, halted=0. Assert reset mid-stream with PC=0x40 -> all values return to reset values immediately, without waiting for a clock edge.
2. Sequential fetch: memory 0x00:0x20080005, 0x04:0x20090003, 3 clocks -> if_id_instr=0x20080005 with pc_plus4=0x4, then 0x20090003 with pc_plus4=0x8; imem_addr reaches 0xC; instr_count=3.
3. Stall held 2 cycles at PC=0x8 -> imem_addr stays 0x8; if_id_* and instr_count unchanged. Release stall -> fetch resumes at 0x8.
4. jb_flag=01, branch_target=0x100 at PC=0x10 -> next cycle imem_addr=0x100 and if_id_valid=0. Following cycle if_id_instr=mem[0x100], pc_plus4=0x104. Repeat with jb_flag=10, jump_addr=0x200 -> same behaviour at 0x200. jb_flag=11 -> sequential.
5. stall=1 together with jb_flag=10 -> PC unchanged, no bubble. Next cycle stall=0, jb_flag=10 -> redirect taken.
6. mem[0x20]=0xFFFFFFFF reached sequentially -> halted=1, PC frozen at 0x20, if_id_valid=0 thereafter; later jb_flag=01 is ignored. Same word fetched while jb_flag=01 -> redirect wins and halted stays 0.
